// File: rtl/seg_score_decoder.sv
// Seven-segment frame decoder: collects NUM_DIGITS segment patterns (MSD first),
// converts them to a binary score and holds it until the consumer takes it.
module seg_score_decoder #(
    parameter int NUM_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic        seg_valid,
    output logic        seg_ready,
    input  logic        frame_clr,
    output logic [13:0] score,
    output logic        score_err,
    output logic        score_valid,
    input  logic        score_ready
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [0:0]  r_state;
    logic [13:0] r_acc;
    logic [2:0]  r_cnt;
    logic        r_err;

    logic [3:0]  w_digit;
    logic        w_invalid;
    logic [13:0] w_acc_next;
    logic        w_seg_xfer;
    logic        w_score_xfer;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_digit   = 4'd0;
        w_invalid = 1'b0;
        case (seg_in)
            7'h3F: w_digit = 4'd0;
            7'h06: w_digit = 4'd1;
            7'h5B: w_digit = 4'd2;
            7'h4F: w_digit = 4'd3;
            7'h66: w_digit = 4'd4;
            7'h6D: w_digit = 4'd5;
            7'h7D: w_digit = 4'd6;
            7'h07: w_digit = 4'd7;
            7'h7F: w_digit = 4'd8;
            7'h6F: w_digit = 4'd9;
            default: w_invalid = 1'b1;
        endcase
    end

    // The largest prior accumulator is 999, so acc*10 + 9 never exceeds 14 bits.
    assign w_acc_next   = (r_acc * 14'd10) + {10'd0, w_digit};
    assign w_seg_xfer   = seg_valid && (r_state == ST_COLLECT);
    assign w_score_xfer = score_ready && (r_state == ST_HOLD);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
            r_acc   <= 14'd0;
            r_cnt   <= 3'd0;
            r_err   <= 1'b0;
        end else if (frame_clr) begin
            r_state <= ST_COLLECT;
            r_acc   <= 14'd0;
            r_cnt   <= 3'd0;
            r_err   <= 1'b0;
        end else if (w_seg_xfer) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 3'd1;
            r_err <= r_err | w_invalid;
            if (r_cnt == LAST_IDX) begin
                r_state <= ST_HOLD;
            end
        end else if (w_score_xfer) begin
            r_state <= ST_COLLECT;
            r_acc   <= 14'd0;
            r_cnt   <= 3'd0;
            r_err   <= 1'b0;
        end
    end

    // Handshake outputs come from registered state only.
    assign seg_ready   = (r_state == ST_COLLECT);
    assign score_valid = (r_state == ST_HOLD);
    assign score       = r_acc;
    assign score_err   = r_err;

endmodule

// File: tb/tb_seg_score_decoder.sv
// Self-checking bench for seg_score_decoder: directed scenarios plus randomized
// back-pressure checked every cycle against a digit-list reference model.
module tb_seg_score_decoder;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = 7'h00;
    logic        seg_valid = 1'b0;
    logic        seg_ready;
    logic        frame_clr = 1'b0;
    logic [13:0] score;
    logic        score_err;
    logic        score_valid;
    logic        score_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    seg_score_decoder #(.NUM_DIGITS(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_in(seg_in),
        .seg_valid(seg_valid),
        .seg_ready(seg_ready),
        .frame_clr(frame_clr),
        .score(score),
        .score_err(score_err),
        .score_valid(score_valid),
        .score_ready(score_ready)
    );

    always #5 clk = ~clk;

    // Reference model: the frame is a list of decoded digits plus an error bit.
    int m_digits[$];
    bit m_err;
    bit m_hold;
    int m_val;
    int delivered;

    logic [6:0] seg_table [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_decode(input logic [6:0] p, output bit bad);
        bad = 1'b1;
        ref_decode = 0;
        for (int i = 0; i < 10; i++) begin
            if (seg_table[i] == p) begin
                bad = 1'b0;
                ref_decode = i;
            end
        end
    endfunction

    function automatic int frame_value();
        int v = 0;
        for (int i = 0; i < m_digits.size(); i++) begin
            int w = 1;
            for (int k = 0; k < m_digits.size() - 1 - i; k++) w = w * 10;
            v = v + m_digits[i] * w;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_err  = 1'b0;
        m_hold = 1'b0;
        m_val  = 0;
    endtask

    task automatic model_update(input logic v, input logic [6:0] s, input logic r, input logic c);
        bit bad;
        int d;
        if (c) begin
            model_reset();
        end else if (!m_hold && v) begin
            d = ref_decode(s, bad);
            m_digits.push_back(d);
            m_err = m_err | bad;
            if (m_digits.size() == N) begin
                m_val  = frame_value();
                m_hold = 1'b1;
            end
        end else if (m_hold && r) begin
            delivered++;
            model_reset();
        end
    endtask

    task automatic compare_outputs();
        check("seg_ready", int'(seg_ready), int'(!m_hold));
        check("score_valid", int'(score_valid), int'(m_hold));
        if (m_hold) begin
            check("score", int'(score), m_val);
            check("score_err", int'(score_err), int'(m_err));
        end
    endtask

    // One clock cycle: compare at the falling edge, drive, let the rising edge act.
    task automatic step(input logic v, input logic [6:0] s, input logic r, input logic c);
        @(negedge clk);
        compare_outputs();
        seg_valid   = v;
        seg_in      = s;
        score_ready = r;
        frame_clr   = c;
        @(posedge clk);
        model_update(v, s, r, c);
        #1;
        seg_valid   = 1'b0;
        score_ready = 1'b0;
        frame_clr   = 1'b0;
    endtask

    task automatic expect_now(input string tag, input int rdy, input int vld, input int sc, input int er);
        @(negedge clk);
        check({tag, "_seg_ready"}, int'(seg_ready), rdy);
        check({tag, "_score_valid"}, int'(score_valid), vld);
        check({tag, "_score"}, int'(score), sc);
        check({tag, "_score_err"}, int'(score_err), er);
    endtask

    initial begin
        int cycles;
        logic v, r, c;
        logic [6:0] s;

        model_reset();
        delivered = 0;

        // Reset values while rst_n is low.
        #2;
        check("rst_seg_ready", int'(seg_ready), 1);
        check("rst_score_valid", int'(score_valid), 0);
        check("rst_score", int'(score), 0);
        check("rst_score_err", int'(score_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2,3,4,5 back to back with the consumer always ready.
        step(1, 7'h5B, 1, 0);
        step(1, 7'h4F, 1, 0);
        step(1, 7'h66, 1, 0);
        step(1, 7'h6D, 1, 0);
        expect_now("f2345", 0, 1, 2345, 0);
        step(0, 7'h00, 1, 0);
        expect_now("f2345_done", 1, 0, 0, 0);

        // 9999 held for 5 stalled cycles, then taken.
        for (int i = 0; i < N; i++) step(1, 7'h6F, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 7'h3F, 0, 0);
        expect_now("f9999", 0, 1, 9999, 0);
        step(0, 7'h00, 1, 0);
        expect_now("f9999_done", 1, 0, 0, 0);

        // Invalid pattern counts as a zero digit and sets the error flag.
        step(1, 7'h06, 0, 0);
        step(1, 7'h00, 0, 0);
        step(1, 7'h7F, 0, 0);
        step(1, 7'h3F, 0, 0);
        expect_now("f1080", 0, 1, 1080, 1);
        step(0, 7'h00, 1, 0);
        for (int i = 0; i < N; i++) step(1, 7'h3F, 0, 0);
        expect_now("f0000", 0, 1, 0, 0);
        step(0, 7'h00, 1, 0);

        // frame_clr discards the partial frame and a simultaneous pattern.
        step(1, 7'h07, 0, 0);
        step(1, 7'h07, 0, 0);
        step(1, 7'h07, 0, 1);
        for (int i = 0; i < N; i++) step(1, 7'h07, 0, 0);
        expect_now("f7777", 0, 1, 7777, 0);

        // frame_clr in HOLD drops the pending score.
        step(0, 7'h00, 1, 1);
        expect_now("clr_hold", 1, 0, 0, 0);

        // Asynchronous reset between edges while holding a score.
        for (int i = 0; i < N; i++) step(1, 7'h66, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_seg_ready", int'(seg_ready), 1);
        check("arst_score_valid", int'(score_valid), 0);
        check("arst_score", int'(score), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 7'h7D, 0, 0);
        step(1, 7'h06, 0, 0);
        step(1, 7'h4F, 0, 0);
        step(1, 7'h6D, 0, 0);
        expect_now("after_rst", 0, 1, 6135, 0);
        step(0, 7'h00, 1, 0);

        // Randomized back-pressure until enough frames have been delivered.
        delivered = 0;
        cycles = 0;
        while (delivered < 1000 && cycles < 60000) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 5);
            c = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) < 8) s = seg_table[$urandom_range(0, 9)];
            else s = 7'($urandom);
            step(v, s, r, c);
            cycles++;
        end
        check("random_frames_delivered", int'(delivered >= 1000), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_score_decoder.md
SEG_SCORE_DECODER -- requirements
Module: seg_score_decoder

Interface
REQ-001: Parameter NUM_DIGITS, default 4, sets the number of digit patterns per frame, most-significant digit first; legal range 1..4.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: seg_in  input  7  segment pattern, bit0=a through bit6=g, 1 = segment lit.
REQ-005: seg_valid  input  1  seg_in holds a pattern to transfer.
REQ-006: seg_ready  output  1  block accepts a pattern this cycle.
REQ-007: frame_clr  input  1  synchronous abort of the current frame.
REQ-008: score  output  14  binary value of the decoded frame.
REQ-009: score_err  output  1  frame contained at least one invalid pattern.
REQ-010: score_valid  output  1  score and score_err are valid.
REQ-011: score_ready  input  1  consumer takes score this cycle.

Function
REQ-012: A transfer on either interface occurs on a rising edge where valid and ready are both 1.
REQ-013: Decode table: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9.
REQ-014: Any other seg_in value, including 0x00, is invalid: it decodes as 0 and sets the sticky frame error flag.
REQ-015: Two states: COLLECT (seg_ready=1, score_valid=0) and HOLD (seg_ready=0, score_valid=1).
REQ-016: In COLLECT, each accepted pattern updates the accumulator to acc*10 + digit and increments the digit count.
REQ-017: When the accepted pattern is digit number NUM_DIGITS, the block enters HOLD on the same edge. score and score_err present the completed frame from the next cycle, one cycle of latency.
REQ-018: In HOLD, score and score_err hold stable until the score transfer, regardless of seg_valid or seg_in.
REQ-019: On the score transfer, the block returns to COLLECT, clearing the accumulator, digit count and error flag on the same edge. seg_ready is 1 in the following cycle.
REQ-020: score_valid does not depend combinationally on score_ready, and seg_ready does not depend combinationally on seg_valid. Both are decoded from registered state only.
REQ-021: In COLLECT, score reflects the running accumulator and score_err the running flag. Both are meaningful only while score_valid=1.
REQ-022: Maximum value is 10^NUM_DIGITS - 1 (9999 when NUM_DIGITS=4), which fits 14 bits without overflow; results are zero-extended.
REQ-023: frame_clr=1 in any state forces COLLECT and clears the accumulator, count and error flag on that edge. A pattern or score handshake in the same cycle is discarded.
REQ-024: frame_clr=1 in HOLD drops the pending score. score_valid is 0 in the next cycle.
REQ-025: An invalid pattern still counts as a digit, so the frame length stays NUM_DIGITS.

Reset
REQ-026: While rst_n=0, and immediately on its assertion without waiting for clk: state=COLLECT, accumulator=0, count=0, error flag=0.
REQ-027: Output values during reset: seg_ready=1, score_valid=0, score=0, score_err=0.
REQ-028: Reset asserted mid-frame or in HOLD discards all partial or pending data.
REQ-029: Deassertion is taken synchronously; the first transfer can occur on the first rising edge after rst_n rises.

Verification
REQ-030: NUM_DIGITS=4; patterns 0x5B,0x4F,0x66,0x6D (2,3,4,5), one per cycle, score_ready=1 -> score_valid=1 for exactly one cycle, score=2345, score_err=0, seg_ready=0 for that cycle only.
REQ-031: Patterns 0x6F x4 with score_ready=0 for 5 cycles -> score=9999 held stable 5 cycles, seg_ready=0 throughout; score_ready=1 -> seg_ready=1 next cycle.
REQ-032: Patterns 0x06,0x00,0x7F,0x3F -> score=1080, score_err=1; the next frame of 0x3F x4 -> score=0, score_err=0.
REQ-033: Two digits accepted, then frame_clr=1 with seg_valid=1 and seg_in=0x07 -> digit discarded; next 4 patterns of 0x07 -> score=7777.
REQ-034: rst_n pulsed low asynchronously between clock edges while in HOLD -> score_valid=0 and seg_ready=1 before the next edge; a subsequent frame decodes correctly.
REQ-035: Random seg_valid and score_ready back-pressure over 1000 frames against a reference model -> no lost, duplicated or reordered frames, and outputs stable while stalled.
